tim_etb_trig_router: RTL and testbench



---
 rtl/tim_etb_pkg.sv | 47 ++++
 rtl/tim_etb_chan.sv | 118 +++++++++++
 rtl/tim_etb_trig_router.sv | 142 ++++++++++++++
 tb/tb_tim_etb_trig_router.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim_etb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tim_etb_pkg
// Description : Shared constants and types for the two-channel event-trigger
//               router: register offsets, action/edge encodings, channel
//               configuration layout and toggle state.
// Revision    : 1.0 - initial release
// ============================================================================
package tim_etb_pkg;

  // Register byte offsets; only bits [4:2] are decoded by the block.
  localparam logic [7:0] CFG0   = 8'h00;
  localparam logic [7:0] CFG1   = 8'h04;
  localparam logic [7:0] STATUS = 8'h08;
  localparam logic [7:0] CNT    = 8'h0C;
  localparam logic [7:0] INTEN  = 8'h10;
  localparam logic [7:0] SWTRIG = 8'h14;

  // What a channel does with each accepted event.
  typedef enum logic [1:0] {
    ACT_NONE = 2'b00,
    ACT_ON   = 2'b01,
    ACT_OFF  = 2'b10,
    ACT_TOG  = 2'b11
  } act_e;

  // Which source transitions count as a hardware event (1x means both).
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  // Toggle action memory: IDLE means the next toggle emits a start pulse.
  typedef enum logic {
    TOG_IDLE  = 1'b0,
    TOG_ARMED = 1'b1
  } tog_e;

  // Channel configuration word, laid out exactly as CHx_CFG[7:0].
  typedef struct packed {
    logic [1:0] edge_sel;
    act_e       action;
    logic [2:0] src_sel;
    logic       en;
  } cfg_t;

endpackage
`default_nettype wire

// File: rtl/tim_etb_chan.sv
`default_nettype none
// ============================================================================
// Module      : tim_etb_chan
// Description : One trigger channel: source select, two-stage sampling, edge
//               detect, event qualification, toggle memory, registered
//               start/stop pulses and a saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tim_etb_chan
  import tim_etb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  input  cfg_t               cfg,
  input  logic               cfg_dis,
  input  logic               sw_trig,
  input  logic               cnt_clr,
  input  logic [NUM_SRC-1:0] src_trig,
  output logic               evt,
  output logic               trig_on,
  output logic               trig_off,
  output logic [CNT_W-1:0]   cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]       w_src_pad;
  logic             w_src;
  logic             w_hit;
  logic             w_evt;
  logic             r_s1;
  logic             r_s2;
  tog_e             r_tog;
  logic             r_on;
  logic             r_off;
  logic [CNT_W-1:0] r_cnt;

  // Widen the source bus to the full 3-bit select range; unused selects read 0.
  always_comb begin
    w_src_pad                = '0;
    w_src_pad[NUM_SRC-1:0]   = src_trig;
  end

  assign w_src = w_src_pad[cfg.src_sel];

  // Edge detection compares the newest sample against the previous one.
  always_comb begin
    w_hit = 1'b0;
    case (cfg.edge_sel)
      EDGE_RISE: w_hit = r_s1 & ~r_s2;
      EDGE_FALL: w_hit = ~r_s1 & r_s2;
      default:   w_hit = r_s1 ^ r_s2;
    endcase
  end

  // A disabling config write suppresses any event landing on the same edge;
  // hardware edge and software trigger together still make a single event.
  assign w_evt = cfg.en & ~cfg_dis & (w_hit | sw_trig);

  // Sample the source, keep the toggle memory and produce one-cycle pulses.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_tog <= TOG_IDLE;
      r_on  <= 1'b0;
      r_off <= 1'b0;
    end else begin
      r_on  <= 1'b0;
      r_off <= 1'b0;
      if (cfg_dis) begin
        r_s1  <= 1'b0;
        r_s2  <= 1'b0;
        r_tog <= TOG_IDLE;
      end else begin
        r_s1 <= w_src;
        r_s2 <= r_s1;
      end
      if (w_evt) begin
        case (cfg.action)
          ACT_NONE: ;
          ACT_ON:   r_on  <= 1'b1;
          ACT_OFF:  r_off <= 1'b1;
          ACT_TOG: begin
            if (r_tog == TOG_IDLE) begin
              r_on  <= 1'b1;
              r_tog <= TOG_ARMED;
            end else begin
              r_off <= 1'b1;
              r_tog <= TOG_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Count accepted events, saturating at all-ones; a clear beats an increment.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_evt && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign evt      = w_evt;
  assign trig_on  = r_on;
  assign trig_off = r_off;
  assign cnt      = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tim_etb_trig_router.sv
`default_nettype none
// ============================================================================
// Module      : tim_etb_trig_router
// Description : Two-channel event-trigger router in front of the dual timer.
//               Holds the APB register file (config, pending, interrupt
//               enable, software trigger, counter clear) and two channels
//               that emit the timer start/stop pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tim_etb_trig_router
  import tim_etb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [7:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  input  logic [NUM_SRC-1:0] src_trig,
  output logic               etb_tim1_trig_en_on,
  output logic               etb_tim1_trig_en_off,
  output logic               etb_tim2_trig_en_on,
  output logic               etb_tim2_trig_en_off,
  output logic               intr
);

  localparam logic [2:0] C_IDX_CFG0   = CFG0[4:2];
  localparam logic [2:0] C_IDX_CFG1   = CFG1[4:2];
  localparam logic [2:0] C_IDX_STATUS = STATUS[4:2];
  localparam logic [2:0] C_IDX_CNT    = CNT[4:2];
  localparam logic [2:0] C_IDX_INTEN  = INTEN[4:2];
  localparam logic [2:0] C_IDX_SWTRIG = SWTRIG[4:2];

  logic             w_wr;
  logic             w_rd;
  logic [2:0]       w_idx;
  logic [1:0]       w_cfg_wr;
  logic [1:0]       w_cfg_dis;
  logic [1:0]       w_sw;
  logic [1:0]       w_w1c;
  logic             w_cnt_clr;
  logic             w_inten_wr;
  logic [1:0]       w_evt;
  logic [1:0]       w_on;
  logic [1:0]       w_off;
  logic [CNT_W-1:0] w_cnt [2];
  logic [31:0]      w_cnt_word;
  logic             w_unused_bits;

  cfg_t [1:0]       r_cfg;
  logic [1:0]       r_pend;
  logic [1:0]       r_inten;

  // Zero-wait APB: a write lands on any edge with psel & penable & pwrite.
  assign w_wr  = psel & penable & pwrite;
  assign w_rd  = psel & ~pwrite;
  assign w_idx = paddr[4:2];

  assign w_cfg_wr[0] = w_wr & (w_idx == C_IDX_CFG0);
  assign w_cfg_wr[1] = w_wr & (w_idx == C_IDX_CFG1);
  assign w_cfg_dis   = w_cfg_wr & {2{~pwdata[0]}};
  assign w_sw        = (w_wr && (w_idx == C_IDX_SWTRIG)) ? pwdata[1:0] : 2'b00;
  assign w_w1c       = (w_wr && (w_idx == C_IDX_STATUS)) ? pwdata[1:0] : 2'b00;
  assign w_cnt_clr   = w_wr & (w_idx == C_IDX_CNT);
  assign w_inten_wr  = w_wr & (w_idx == C_IDX_INTEN);

  // Address and data bits outside the decoded register fields.
  assign w_unused_bits = &{1'b0, paddr[7:5], paddr[1:0], pwdata[31:8]};

  // Channel 0 drives timer 1, channel 1 drives timer 2.
  generate
    for (genvar c = 0; c < 2; c++) begin : g_chan
      tim_etb_chan #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
      ) u_chan (
        .pclk     (pclk),
        .presetn  (presetn),
        .cfg      (r_cfg[c]),
        .cfg_dis  (w_cfg_dis[c]),
        .sw_trig  (w_sw[c]),
        .cnt_clr  (w_cnt_clr),
        .src_trig (src_trig),
        .evt      (w_evt[c]),
        .trig_on  (w_on[c]),
        .trig_off (w_off[c]),
        .cnt      (w_cnt[c])
      );
    end
  endgenerate

  // Config, interrupt enable and pending; a new event wins over its own W1C.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_cfg   <= '0;
      r_pend  <= '0;
      r_inten <= '0;
    end else begin
      if (w_cfg_wr[0]) begin
        r_cfg[0] <= cfg_t'(pwdata[7:0]);
      end
      if (w_cfg_wr[1]) begin
        r_cfg[1] <= cfg_t'(pwdata[7:0]);
      end
      if (w_inten_wr) begin
        r_inten <= pwdata[1:0];
      end
      r_pend <= (r_pend & ~w_w1c) | w_evt;
    end
  end

  // Read mux: only during a read select; SWTRIG and unmapped offsets read 0.
  always_comb begin
    w_cnt_word                = '0;
    w_cnt_word[CNT_W-1:0]     = w_cnt[0];
    w_cnt_word[16+CNT_W-1:16] = w_cnt[1];
    prdata                    = '0;
    if (w_rd) begin
      case (w_idx)
        C_IDX_CFG0:   prdata = {24'd0, r_cfg[0]};
        C_IDX_CFG1:   prdata = {24'd0, r_cfg[1]};
        C_IDX_STATUS: prdata = {30'd0, r_pend};
        C_IDX_CNT:    prdata = w_cnt_word;
        C_IDX_INTEN:  prdata = {30'd0, r_inten};
        default:      prdata = '0;
      endcase
    end
  end

  assign intr                 = |(r_pend & r_inten);
  assign etb_tim1_trig_en_on  = w_on[0];
  assign etb_tim1_trig_en_off = w_off[0];
  assign etb_tim2_trig_en_on  = w_on[1];
  assign etb_tim2_trig_en_off = w_off[1];

endmodule
`default_nettype wire

// File: tb/tb_tim_etb_trig_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_tim_etb_trig_router
// Description : Self-checking bench for the event-trigger router. Directed
//               scenarios followed by randomized traffic, all compared each
//               cycle against a register/event-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tim_etb_trig_router;

  localparam int NUM_SRC = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               pclk = 1'b0;
  logic               presetn;
  logic               psel;
  logic               penable;
  logic               pwrite;
  logic [7:0]         paddr;
  logic [31:0]        pwdata;
  logic [31:0]        prdata;
  logic [NUM_SRC-1:0] src_trig;
  logic               on1, off1, on2, off2, intr;

  int n_pass;
  int n_chk;

  // Reference model state, in register / event terms.
  int m_cfg   [2];
  int m_new   [2];   // source value sampled at the most recent edge
  int m_old   [2];   // source value sampled one edge earlier
  int m_tog   [2];   // 1 once a toggle has emitted a start
  int m_cnt   [2];
  int m_on    [2];
  int m_off   [2];
  int m_pend;
  int m_inten;

  tim_etb_trig_router #(
    .NUM_SRC (NUM_SRC),
    .CNT_W   (CNT_W)
  ) dut (
    .pclk                 (pclk),
    .presetn              (presetn),
    .psel                 (psel),
    .penable              (penable),
    .pwrite               (pwrite),
    .paddr                (paddr),
    .pwdata               (pwdata),
    .prdata               (prdata),
    .src_trig             (src_trig),
    .etb_tim1_trig_en_on  (on1),
    .etb_tim1_trig_en_off (off1),
    .etb_tim2_trig_en_on  (on2),
    .etb_tim2_trig_en_off (off2),
    .intr                 (intr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_read(input int idx);
    case (idx)
      0:       return m_cfg[0];
      1:       return m_cfg[1];
      2:       return m_pend;
      3:       return (m_cnt[1] << 16) | m_cnt[0];
      4:       return m_inten;
      default: return 0;
    endcase
  endfunction

  // Apply one clock edge worth of register-map and event rules.
  task automatic model_edge();
    int wr;
    int idx;
    int ev [2];
    int w1c;
    if (!presetn) begin
      for (int c = 0; c < 2; c++) begin
        m_cfg[c] = 0; m_new[c] = 0; m_old[c] = 0; m_tog[c] = 0;
        m_cnt[c] = 0; m_on[c] = 0; m_off[c] = 0;
      end
      m_pend  = 0;
      m_inten = 0;
      return;
    end
    wr  = int'(psel && penable && pwrite);
    idx = int'(paddr[4:2]);
    for (int c = 0; c < 2; c++) begin
      int en, sel, act, edg, hit, sw, dis, smp;
      en  = m_cfg[c] & 1;
      sel = (m_cfg[c] >> 1) & 7;
      act = (m_cfg[c] >> 4) & 3;
      edg = (m_cfg[c] >> 6) & 3;
      if (edg == 0)      hit = int'(m_new[c] == 1 && m_old[c] == 0);
      else if (edg == 1) hit = int'(m_new[c] == 0 && m_old[c] == 1);
      else               hit = int'(m_new[c] != m_old[c]);
      sw    = int'(wr == 1 && idx == 5 && pwdata[c] == 1'b1);
      dis   = int'(wr == 1 && idx == c && pwdata[0] == 1'b0);
      ev[c] = int'(en == 1 && dis == 0 && (hit == 1 || sw == 1));
      m_on[c]  = 0;
      m_off[c] = 0;
      if (ev[c] == 1) begin
        if (act == 1) m_on[c] = 1;
        else if (act == 2) m_off[c] = 1;
        else if (act == 3) begin
          if (m_tog[c] == 1) begin m_off[c] = 1; m_tog[c] = 0; end
          else begin m_on[c] = 1; m_tog[c] = 1; end
        end
      end
      if (wr == 1 && idx == 3) m_cnt[c] = 0;
      else if (ev[c] == 1 && m_cnt[c] < CNT_MAX) m_cnt[c]++;
      smp = (sel < NUM_SRC) ? int'(src_trig[sel]) : 0;
      if (dis == 1) begin
        m_new[c] = 0; m_old[c] = 0; m_tog[c] = 0;
      end else begin
        m_old[c] = m_new[c];
        m_new[c] = smp;
      end
    end
    w1c = (wr == 1 && idx == 2) ? int'(pwdata[1:0]) : 0;
    m_pend = (m_pend & ~w1c & 3) | ev[0] | (ev[1] << 1);
    if (wr == 1 && idx == 0) m_cfg[0] = int'(pwdata[7:0]);
    if (wr == 1 && idx == 1) m_cfg[1] = int'(pwdata[7:0]);
    if (wr == 1 && idx == 4) m_inten = int'(pwdata[1:0]);
  endtask

  // One cycle: check read data before the edge, outputs after it.
  task automatic step();
    int exp_rd;
    #1;
    exp_rd = (psel && !pwrite) ? m_read(int'(paddr[4:2])) : 0;
    chk("prdata", prdata, exp_rd);
    @(posedge pclk);
    model_edge();
    #1;
    chk("tim1_on",  32'(on1),  m_on[0]);
    chk("tim1_off", 32'(off1), m_off[0]);
    chk("tim2_on",  32'(on2),  m_on[1]);
    chk("tim2_off", 32'(off2), m_off[1]);
    chk("intr",     32'(intr), int'((m_pend & m_inten) != 0));
  endtask

  task automatic bus_idle();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    step();
    bus_idle();
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    chk(tag, prdata, exp);
    step();
    bus_idle();
  endtask

  initial begin
    int on_at, off_at, npulse, r;
    n_pass = 0;
    n_chk  = 0;
    presetn  = 1'b0;
    src_trig = '0;
    bus_idle();

    // Reset state.
    step(); step();
    chk("rst_outs", {27'd0, on1, off1, on2, off2, intr}, 32'd0);
    rd(8'h00, 32'd0, "rst_cfg0");
    rd(8'h0C, 32'd0, "rst_cnt");
    presetn = 1'b1;
    step();

    // Channel 0: source 1, action on, rising edge; two-edge latency.
    wr(8'h00, 32'h13);
    step();
    src_trig[1] = 1'b1;
    step();
    chk("ch0_on_early", 32'(on1), 32'd0);
    step();
    chk("ch0_on_lat", 32'(on1), 32'd1);
    step();
    chk("ch0_on_once", 32'(on1), 32'd0);
    rd(8'h0C, 32'h1, "ch0_cnt");
    rd(8'h08, 32'h1, "ch0_status");
    src_trig = '0;
    step();

    // Channel 1: source 0, toggle, both edges; 3-cycle high source.
    wr(8'h04, 32'hB1);
    step();
    on_at  = -1;
    off_at = -1;
    for (int i = 0; i < 8; i++) begin
      src_trig[0] = (i < 3);
      step();
      if (on2 && on_at < 0) on_at = i;
      if (off2 && off_at < 0) off_at = i;
    end
    chk("ch1_on_at", on_at, 32'd1);
    chk("ch1_on_off_gap", off_at - on_at, 32'd3);
    rd(8'h0C, 32'h0002_0001, "ch1_cnt");
    rd(8'h08, 32'h3, "ch1_status");

    // Event and W1C of the same pending bit on one edge: set wins.
    wr(8'h08, 32'h3);
    wr(8'h10, 32'h3);
    chk("intr_clear", 32'(intr), 32'd0);
    src_trig[1] = 1'b1;
    step();
    wr(8'h08, 32'h1);
    chk("intr_set_wins", 32'(intr), 32'd1);
    rd(8'h08, 32'h1, "pend_set_wins");
    src_trig = '0;
    step();
    wr(8'h08, 32'h1);
    chk("intr_w1c_drop", 32'(intr), 32'd0);

    // Saturation with 260 software triggers, then clear.
    wr(8'h0C, 32'h0);
    for (int i = 0; i < 260; i++) wr(8'h14, 32'h1);
    rd(8'h0C, 32'h0000_00FF, "cnt_sat");
    wr(8'h0C, 32'h0);
    rd(8'h0C, 32'h0, "cnt_clr");

    // Software and hardware trigger on the same edge: one event.
    src_trig[1] = 1'b1;
    step();
    wr(8'h14, 32'h1);
    chk("sw_hw_pulse", 32'(on1), 32'd1);
    step();
    chk("sw_hw_single", 32'(on1), 32'd0);
    rd(8'h0C, 32'h1, "sw_hw_cnt");
    src_trig = '0;
    step();

    // Disabled channel: no pulse, no count.
    wr(8'h04, 32'hB0);
    wr(8'h0C, 32'h0);
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      src_trig[0] = i[0];
      step();
      npulse += int'(on2 | off2);
    end
    wr(8'h14, 32'h2);
    npulse += int'(on2 | off2);
    step();
    npulse += int'(on2 | off2);
    chk("dis_no_pulse", npulse, 32'd0);
    rd(8'h0C, 32'h0, "dis_no_cnt");

    // Reset while toggling; toggle restarts with a start pulse.
    src_trig = '0;
    wr(8'h04, 32'hB1);
    src_trig[0] = 1'b1;
    step(); step();
    presetn  = 1'b0;
    src_trig = '0;
    step(); step();
    chk("rst2_outs", {27'd0, on1, off1, on2, off2, intr}, 32'd0);
    presetn = 1'b1;
    rd(8'h04, 32'd0, "rst2_cfg1");
    rd(8'h0C, 32'd0, "rst2_cnt");
    rd(8'h08, 32'd0, "rst2_status");
    wr(8'h04, 32'hB1);
    step();
    src_trig[0] = 1'b1;
    step(); step();
    chk("tog_restart_on",  32'(on2),  32'd1);
    chk("tog_restart_off", 32'(off2), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      src_trig = NUM_SRC'($urandom);
      r = $urandom_range(0, 99);
      presetn = (r != 99);
      if (r < 14) begin
        int sel;
        sel = $urandom_range(0, 5);
        if (sel == 3 && $urandom_range(0, 3) != 0) sel = 5;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr  = {3'($urandom), 3'(sel), 2'($urandom)};
        pwdata = $urandom;
      end else if (r < 45) begin
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 8'($urandom);
      end
      step();
      bus_idle();
    end
    presetn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
